sopc: RTL and testbench

SOPC -- requirements
Module: sopc

---
 rtl/sopc.sv | 221 ++++++++++++++++++++++
 tb/tb_sopc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sopc.sv
// Minimal SOPC: 5-stage MIPS32 subset pipeline with a combinational instruction ROM.
// Define SOPC_REGFILE_RESET_EN to clear the register file during reset.

module sopc_rom #(
  parameter int unsigned ROM_DEPTH = 1024
) (
  input  logic [$clog2(ROM_DEPTH)-1:0] addr,
  output logic [31:0]                  data
);
  logic [31:0] storage [0:ROM_DEPTH-1];

  assign data = storage[addr];
endmodule

module sopc_regfile (
  input  logic        clock,
`ifdef SOPC_REGFILE_RESET_EN
  input  logic        reset,
`endif
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] storage [0:31];

`ifdef SOPC_REGFILE_RESET_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) storage[i] <= '0;
    end else if (we && waddr != '0) begin
      storage[waddr] <= wdata;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (we && waddr != '0) storage[waddr] <= wdata;
  end
`endif

  // Write-through so an ID read sees the WB write of the same cycle.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && waddr == raddr1) ? wdata : storage[raddr1];
    if (raddr2 != '0) rdata2 = (we && waddr == raddr2) ? wdata : storage[raddr2];
  end
endmodule

module sopc_cpu #(
  parameter int unsigned ROM_DEPTH = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
  input  logic [31:0]                  inst
);
  localparam int unsigned AW = $clog2(ROM_DEPTH);

  typedef enum logic [2:0] {ALU_OR, ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL} alu_op_t;

  logic [31:0] pc, id_pc, id_inst;
  alu_op_t     ex_op;
  logic [31:0] ex_a, ex_b, ex_result, mem_result, wb_result;
  logic [4:0]  ex_wd, mem_wd, wb_wd;
  logic        ex_wreg, mem_wreg, wb_wreg;

  logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;
  logic [31:0] next_pc, slot_pc, d_a, d_b;
  alu_op_t     d_op;
  logic [4:0]  d_wd;
  logic        d_we;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  assign rom_addr = pc[AW+1:2];
  assign opcode   = id_inst[31:26];
  assign rs       = id_inst[25:21];
  assign rt       = id_inst[20:16];
  assign rd       = id_inst[15:11];
  assign sa       = id_inst[10:6];
  assign funct    = id_inst[5:0];
  assign imm      = id_inst[15:0];
  assign slot_pc  = id_pc + 32'd4;

  sopc_regfile register (
    .clock  (clock),
`ifdef SOPC_REGFILE_RESET_EN
    .reset  (reset),
`endif
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_result),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // EX overrides MEM because it holds the younger producer.
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (mem_wreg && mem_wd == rs) rs_val = mem_result;
    if (mem_wreg && mem_wd == rt) rt_val = mem_result;
    if (ex_wreg && ex_wd == rs) rs_val = ex_result;
    if (ex_wreg && ex_wd == rt) rt_val = ex_result;
  end

  always_comb begin
    next_pc = pc + 32'd4;
    d_op    = ALU_OR;
    d_a     = '0;
    d_b     = '0;
    d_wd    = '0;
    d_we    = 1'b0;
    case (opcode)
      6'h00: begin
        d_a  = rs_val;
        d_b  = rt_val;
        d_wd = rd;
        case (funct)
          6'h21: begin d_op = ALU_ADD; d_we = 1'b1; end
          6'h23: begin d_op = ALU_SUB; d_we = 1'b1; end
          6'h24: begin d_op = ALU_AND; d_we = 1'b1; end
          6'h25: begin d_op = ALU_OR;  d_we = 1'b1; end
          6'h26: begin d_op = ALU_XOR; d_we = 1'b1; end
          6'h00: begin d_op = ALU_SLL; d_a = rt_val; d_b = {27'd0, sa}; d_we = 1'b1; end
          6'h08: next_pc = rs_val;
          default: ;
        endcase
      end
      6'h09: begin d_op = ALU_ADD; d_a = rs_val; d_b = {{16{imm[15]}}, imm}; d_wd = rt; d_we = 1'b1; end
      6'h0D: begin d_a = rs_val; d_b = {16'd0, imm}; d_wd = rt; d_we = 1'b1; end
      6'h0F: begin d_a = {imm, 16'd0}; d_wd = rt; d_we = 1'b1; end
      6'h02: next_pc = {slot_pc[31:28], id_inst[25:0], 2'b00};
      6'h03: begin
        next_pc = {slot_pc[31:28], id_inst[25:0], 2'b00};
        d_a     = id_pc + 32'd8;
        d_wd    = 5'd31;
        d_we    = 1'b1;
      end
      6'h04: if (rs_val == rt_val) next_pc = slot_pc + {{14{imm[15]}}, imm, 2'b00};
      6'h05: if (rs_val != rt_val) next_pc = slot_pc + {{14{imm[15]}}, imm, 2'b00};
      default: ;
    endcase
    if (d_wd == '0) d_we = 1'b0;
  end

  always_comb begin
    case (ex_op)
      ALU_ADD: ex_result = ex_a + ex_b;
      ALU_SUB: ex_result = ex_a - ex_b;
      ALU_AND: ex_result = ex_a & ex_b;
      ALU_XOR: ex_result = ex_a ^ ex_b;
      ALU_SLL: ex_result = ex_a << ex_b[4:0];
      default: ex_result = ex_a | ex_b;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      id_pc      <= '0;
      id_inst    <= '0;
      ex_op      <= ALU_OR;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_wd      <= '0;
      ex_wreg    <= 1'b0;
      mem_result <= '0;
      mem_wd     <= '0;
      mem_wreg   <= 1'b0;
      wb_result  <= '0;
      wb_wd      <= '0;
      wb_wreg    <= 1'b0;
    end else begin
      pc         <= next_pc;
      id_pc      <= pc;
      id_inst    <= inst;
      ex_op      <= d_op;
      ex_a       <= d_a;
      ex_b       <= d_b;
      ex_wd      <= d_wd;
      ex_wreg    <= d_we;
      mem_result <= ex_result;
      mem_wd     <= ex_wd;
      mem_wreg   <= ex_wreg;
      wb_result  <= mem_result;
      wb_wd      <= mem_wd;
      wb_wreg    <= mem_wreg;
    end
  end
endmodule

module sopc #(
  parameter int unsigned ROM_DEPTH = 1024
) (
  input logic clock,
  input logic reset
);
  logic [$clog2(ROM_DEPTH)-1:0] rom_addr;
  logic [31:0]                  rom_data;

  sopc_cpu #(.ROM_DEPTH(ROM_DEPTH)) cpu (
    .clock    (clock),
    .reset    (reset),
    .rom_addr (rom_addr),
    .inst     (rom_data)
  );

  sopc_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
    .addr (rom_addr),
    .data (rom_data)
  );
endmodule

// File: tb/tb_sopc.sv
// Directed bench for sopc: table of small programs plus timing-exact hand sequences.

module tb_sopc;
  localparam int unsigned DEPTH = 32;

  typedef logic [31:0] prog_t [16];
  typedef struct {
    string       name;
    prog_t       prog;
    int unsigned cycles;
    logic [4:0]  rd  [6];
    logic [31:0] exp [6];
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sopc #(.ROM_DEPTH(DEPTH)) dut (.clock(clock), .reset(reset));

  always #5 clock = ~clock;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] funct);
    return {6'h00, rs, rt, rd, sa, funct};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] word);
    return {op, word};
  endfunction

  function automatic logic [31:0] rf(input logic [4:0] i);
    return dut.cpu.register.storage[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input prog_t p);
    for (int unsigned i = 0; i < DEPTH; i++) dut.rom.storage[i] = (i < 16) ? p[i] : 32'h0;
  endtask

  task automatic start(input prog_t p, input int unsigned hold);
    reset = 1'b0;
    load(p);
    repeat (hold) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  vec_t  tbl [7];
  prog_t p;
  prog_t loop_prog;
  prog_t dep_prog;
  logic [31:0] exp1;

  initial begin
    // ---- table of programs ----
    p = '{default: '0};
    p[0] = itype(6'h0D, 0, 1, 16'd5);
    p[1] = rtype(1, 1, 2, 0, 6'h21);
    p[2] = rtype(2, 1, 3, 0, 6'h21);
    p[3] = jtype(6'h02, 26'd3);
    dep_prog = p;
    tbl[0].name = "dep"; tbl[0].prog = p; tbl[0].cycles = 25;
    tbl[0].rd  = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0};
    tbl[0].exp = '{32'd5, 32'd10, 32'd15, 32'd0, 32'd0, 32'd0};

    p = '{default: '0};
    p[0] = itype(6'h0D, 0, 9, 16'd3);
    p[1] = itype(6'h04, 0, 0, 16'd2);
    p[2] = itype(6'h0D, 0, 4, 16'd7);
    p[3] = itype(6'h0D, 0, 9, 16'h55);
    p[4] = itype(6'h0D, 0, 8, 16'd9);
    p[5] = jtype(6'h02, 26'd5);
    tbl[1].name = "beq"; tbl[1].prog = p; tbl[1].cycles = 25;
    tbl[1].rd  = '{5'd4, 5'd8, 5'd9, 5'd0, 5'd0, 5'd0};
    tbl[1].exp = '{32'd7, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0};

    p = '{default: '0};
    p[0] = itype(6'h0D, 0, 11, 16'd4);
    p[1] = itype(6'h0D, 0, 1, 16'd1);
    p[2] = itype(6'h05, 1, 0, 16'd2);
    p[3] = itype(6'h0D, 0, 10, 16'd1);
    p[4] = itype(6'h0D, 0, 11, 16'h22);
    p[5] = itype(6'h05, 1, 1, 16'd5);
    p[6] = itype(6'h0D, 0, 12, 16'd2);
    p[7] = itype(6'h0D, 0, 13, 16'd3);
    p[8] = jtype(6'h02, 26'd8);
    tbl[2].name = "bne"; tbl[2].prog = p; tbl[2].cycles = 25;
    tbl[2].rd  = '{5'd11, 5'd10, 5'd12, 5'd13, 5'd0, 5'd0};
    tbl[2].exp = '{32'd4, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0};

    p = '{default: '0};
    p[0] = jtype(6'h03, 26'd6);
    p[1] = itype(6'h0D, 0, 14, 16'd1);
    p[2] = itype(6'h0D, 0, 15, 16'd2);
    p[3] = jtype(6'h02, 26'd3);
    p[6] = rtype(31, 0, 0, 0, 6'h08);
    p[7] = itype(6'h0D, 0, 16, 16'd6);
    p[8] = itype(6'h0D, 0, 16, 16'h77);
    tbl[3].name = "jal_jr"; tbl[3].prog = p; tbl[3].cycles = 25;
    tbl[3].rd  = '{5'd31, 5'd14, 5'd15, 5'd16, 5'd0, 5'd0};
    tbl[3].exp = '{32'd8, 32'd1, 32'd2, 32'd6, 32'd0, 32'd0};

    p = '{default: '0};
    p[0] = itype(6'h0D, 0, 18, 16'h99);
    p[1] = itype(6'h0D, 0, 0, 16'h1234);
    p[2] = rtype(0, 0, 18, 0, 6'h21);
    p[3] = itype(6'h0F, 0, 5, 16'h1234);
    p[4] = itype(6'h09, 0, 19, 16'hFFFF);
    p[5] = itype(6'h0D, 0, 20, 16'h8000);
    p[6] = itype(6'h09, 19, 21, 16'd2);
    p[7] = jtype(6'h02, 26'd7);
    tbl[4].name = "zero_lui_imm"; tbl[4].prog = p; tbl[4].cycles = 25;
    tbl[4].rd  = '{5'd18, 5'd5, 5'd19, 5'd20, 5'd21, 5'd0};
    tbl[4].exp = '{32'd0, 32'h12340000, 32'hFFFFFFFF, 32'h00008000, 32'd1, 32'd0};

    p = '{default: '0};
    p[0]  = itype(6'h0F, 0, 1, 16'hF0F0);
    p[1]  = itype(6'h0D, 1, 1, 16'h00FF);
    p[2]  = itype(6'h0D, 0, 2, 16'h0F0F);
    p[3]  = itype(6'h0D, 0, 9, 16'h33);
    p[4]  = rtype(1, 2, 3, 0, 6'h24);
    p[5]  = rtype(1, 2, 4, 0, 6'h26);
    p[6]  = rtype(2, 1, 5, 0, 6'h23);
    p[7]  = rtype(0, 2, 6, 5'd4, 6'h00);
    p[8]  = rtype(1, 1, 7, 0, 6'h21);
    p[9]  = rtype(1, 2, 8, 0, 6'h25);
    p[10] = rtype(1, 2, 9, 0, 6'h20);
    p[11] = 32'hFC09FFFF;
    p[12] = jtype(6'h02, 26'd12);
    tbl[5].name = "alu"; tbl[5].prog = p; tbl[5].cycles = 25;
    tbl[5].rd  = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9};
    tbl[5].exp = '{32'h0000000F, 32'hF0F00FF0, 32'h0F100E10, 32'h0000F0F0, 32'hE1E001FE, 32'h33};

    p = '{default: '0};
    p[0] = jtype(6'h03, 26'd2);
    tbl[6].name = "alias"; tbl[6].prog = p; tbl[6].cycles = 50;
    tbl[6].rd  = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    tbl[6].exp = '{32'd136, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    loop_prog = '{default: '0};
    loop_prog[0] = itype(6'h0D, 0, 1, 16'd0);
    loop_prog[1] = itype(6'h09, 1, 1, 16'd1);
    loop_prog[2] = jtype(6'h02, 26'd1);

    // ---- reset state and counting loop ----
    reset = 1'b0;
    load(loop_prog);
    repeat (10) @(posedge clock);
    #1;
    check("reset_pc", dut.cpu.pc, 32'h0);
    check("reset_id_inst", dut.cpu.id_inst, 32'h0);
    check("reset_wreg", {29'd0, dut.cpu.ex_wreg, dut.cpu.mem_wreg, dut.cpu.wb_wreg}, 32'h0);
`ifdef SOPC_REGFILE_RESET_EN
    for (int unsigned r = 0; r < 32; r++)
      check($sformatf("rfreset_r%0d", r), rf(r[4:0]), 32'h0);
`endif
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 5) begin
        exp1 = (k == 5) ? 32'd0 : 32'(1 + (k - 6) / 3);
        check($sformatf("loop_k%0d", k), rf(5'd1), exp1);
      end
    end

    // ---- reset mid-loop: addiu fetched on the last edge is in flight ----
    #2 reset = 1'b0;
    #1;
    check("midreset_pc", dut.cpu.pc, 32'h0);
    check("midreset_wb", {31'd0, dut.cpu.wb_wreg}, 32'h0);
    repeat (6) step();
`ifdef SOPC_REGFILE_RESET_EN
    check("midreset_r1", rf(5'd1), 32'd0);
`else
    check("midreset_r1", rf(5'd1), 32'd5);
`endif
    reset = 1'b1;
    repeat (5) step();
    check("restart_r1_ori", rf(5'd1), 32'd0);
    step();
    check("restart_r1_inc", rf(5'd1), 32'd1);

    // ---- back-to-back dependency, exact writeback edges ----
    start(dep_prog, 3);
    repeat (5) step();
    check("nobubble_r1_e5", rf(5'd1), 32'd5);
    step();
    check("nobubble_r2_e6", rf(5'd2), 32'd10);
    step();
    check("nobubble_r3_e7", rf(5'd3), 32'd15);

    // ---- table ----
    for (int i = 0; i < 7; i++) begin
      start(tbl[i].prog, 3);
      repeat (tbl[i].cycles) step();
      for (int j = 0; j < 6; j++)
        if (tbl[i].rd[j] != 5'd0)
          check($sformatf("%s_r%0d", tbl[i].name, tbl[i].rd[j]), rf(tbl[i].rd[j]), tbl[i].exp[j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
